// File: rtl/dec_ctrl_hazard_if.sv
// Decode-stage bus: instruction and operand sources toward decode, decoded controls and
// forwarded operands back toward the register file / ID-EX register.
interface dec_ctrl_hazard_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;
  localparam int unsigned ALUW = 5;
  localparam int unsigned BRW  = 4;

  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] aluOutE;
  logic [XLEN-1:0] resM;
  logic [XLEN-1:0] rstW;

  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] num;
  logic [RAW-1:0]  wra;
  logic [ALUW-1:0] aluOP;
  logic [BRW-1:0]  brOP;
  logic            sA0;
  logic            sA;
  logic            sB;
  logic            sWRD;
  logic            sByte;
  logic            dMemWe;
  logic            regWe;
  logic            pause;

  modport master (
    output inst, rf_rd1, rf_rd2, aluOutE, resM, rstW,
    input  rd1, rd2, num, wra, aluOP, brOP, sA0, sA, sB, sWRD, sByte, dMemWe, regWe, pause
  );

  modport slave (
    input  inst, rf_rd1, rf_rd2, aluOutE, resM, rstW,
    output rd1, rd2, num, wra, aluOP, brOP, sA0, sA, sB, sWRD, sByte, dMemWe, regWe, pause
  );
endinterface

// File: rtl/dec_ctrl_hazard.sv
// Decode-stage control: instruction decode, immediate extension, operand forwarding and
// load-use stall, with an internal E/M/W destination tracker.
module dec_ctrl_hazard (
  input  logic             clk,
  input  logic             rstn,
  dec_ctrl_hazard_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;
  localparam int unsigned OPW  = 6;
  localparam int unsigned ALUW = 5;
  localparam int unsigned BRW  = 4;
  localparam int unsigned IMMW = 16;

  localparam logic [OPW-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OPW-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OPW-1:0] OP_J       = 6'h02;
  localparam logic [OPW-1:0] OP_JAL     = 6'h03;
  localparam logic [OPW-1:0] OP_BEQ     = 6'h04;
  localparam logic [OPW-1:0] OP_BNE     = 6'h05;
  localparam logic [OPW-1:0] OP_BLEZ    = 6'h06;
  localparam logic [OPW-1:0] OP_BGTZ    = 6'h07;
  localparam logic [OPW-1:0] OP_ADDI    = 6'h08;
  localparam logic [OPW-1:0] OP_ADDIU   = 6'h09;
  localparam logic [OPW-1:0] OP_SLTI    = 6'h0A;
  localparam logic [OPW-1:0] OP_SLTIU   = 6'h0B;
  localparam logic [OPW-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OPW-1:0] OP_ORI     = 6'h0D;
  localparam logic [OPW-1:0] OP_XORI    = 6'h0E;
  localparam logic [OPW-1:0] OP_LUI     = 6'h0F;
  localparam logic [OPW-1:0] OP_LB      = 6'h20;
  localparam logic [OPW-1:0] OP_LW      = 6'h23;
  localparam logic [OPW-1:0] OP_SB      = 6'h28;
  localparam logic [OPW-1:0] OP_SW      = 6'h2B;

  localparam logic [OPW-1:0] FN_SLL  = 6'h00;
  localparam logic [OPW-1:0] FN_SRL  = 6'h02;
  localparam logic [OPW-1:0] FN_SRA  = 6'h03;
  localparam logic [OPW-1:0] FN_SLLV = 6'h04;
  localparam logic [OPW-1:0] FN_SRLV = 6'h06;
  localparam logic [OPW-1:0] FN_SRAV = 6'h07;
  localparam logic [OPW-1:0] FN_JR   = 6'h08;
  localparam logic [OPW-1:0] FN_JALR = 6'h09;
  localparam logic [OPW-1:0] FN_ADD  = 6'h20;
  localparam logic [OPW-1:0] FN_ADDU = 6'h21;
  localparam logic [OPW-1:0] FN_SUB  = 6'h22;
  localparam logic [OPW-1:0] FN_SUBU = 6'h23;
  localparam logic [OPW-1:0] FN_AND  = 6'h24;
  localparam logic [OPW-1:0] FN_OR   = 6'h25;
  localparam logic [OPW-1:0] FN_XOR  = 6'h26;
  localparam logic [OPW-1:0] FN_NOR  = 6'h27;
  localparam logic [OPW-1:0] FN_SLT  = 6'h2A;
  localparam logic [OPW-1:0] FN_SLTU = 6'h2B;

  localparam logic [ALUW-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALUW-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALUW-1:0] ALU_AND  = 5'd2;
  localparam logic [ALUW-1:0] ALU_OR   = 5'd3;
  localparam logic [ALUW-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALUW-1:0] ALU_NOR  = 5'd5;
  localparam logic [ALUW-1:0] ALU_SLT  = 5'd6;
  localparam logic [ALUW-1:0] ALU_SLTU = 5'd7;
  localparam logic [ALUW-1:0] ALU_SLL  = 5'd8;
  localparam logic [ALUW-1:0] ALU_SRL  = 5'd9;
  localparam logic [ALUW-1:0] ALU_SRA  = 5'd10;
  localparam logic [ALUW-1:0] ALU_LUI  = 5'd11;
  localparam logic [ALUW-1:0] ALU_LINK = 5'd12;

  localparam logic [BRW-1:0] BR_NONE = 4'd0;
  localparam logic [BRW-1:0] BR_BEQ  = 4'd1;
  localparam logic [BRW-1:0] BR_BNE  = 4'd2;
  localparam logic [BRW-1:0] BR_BLEZ = 4'd3;
  localparam logic [BRW-1:0] BR_BGTZ = 4'd4;
  localparam logic [BRW-1:0] BR_BLTZ = 4'd5;
  localparam logic [BRW-1:0] BR_BGEZ = 4'd6;
  localparam logic [BRW-1:0] BR_J    = 4'd7;
  localparam logic [BRW-1:0] BR_JAL  = 4'd8;
  localparam logic [BRW-1:0] BR_JR   = 4'd9;
  localparam logic [BRW-1:0] BR_JALR = 4'd10;

  localparam logic [RAW-1:0] REG_ZERO = 5'd0;
  localparam logic [RAW-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [RAW-1:0] wra;
    logic           we;
    logic           load;
  } trk_t;

  logic [OPW-1:0]  op;
  logic [OPW-1:0]  funct;
  logic [RAW-1:0]  rs;
  logic [RAW-1:0]  rt;
  logic [RAW-1:0]  rd;
  logic [RAW-1:0]  shamt;
  logic [IMMW-1:0] imm16;

  assign op    = bus.inst[31:26];
  assign rs    = bus.inst[25:21];
  assign rt    = bus.inst[20:16];
  assign rd    = bus.inst[15:11];
  assign shamt = bus.inst[10:6];
  assign funct = bus.inst[5:0];

  logic [ALUW-1:0] alu_op;
  logic [BRW-1:0]  br_op;
  logic [RAW-1:0]  wra;
  logic            s_a0;
  logic            s_a;
  logic            s_b;
  logic            s_wrd;
  logic            s_byte;
  logic            dmem_we;
  logic            reg_we;
  logic            is_load;
  logic            s_imme;
  logic            sign_ext;

  // Instruction decode; anything not recognised leaves every control at zero (NOP).
  always_comb begin
    alu_op   = ALU_ADD;
    br_op    = BR_NONE;
    wra      = REG_ZERO;
    s_a0     = 1'b0;
    s_a      = 1'b0;
    s_b      = 1'b0;
    s_wrd    = 1'b0;
    s_byte   = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    is_load  = 1'b0;
    s_imme   = 1'b0;
    sign_ext = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_ADDU: begin alu_op = ALU_ADD;  reg_we = 1'b1; wra = rd; end
          FN_SUB, FN_SUBU: begin alu_op = ALU_SUB;  reg_we = 1'b1; wra = rd; end
          FN_AND:          begin alu_op = ALU_AND;  reg_we = 1'b1; wra = rd; end
          FN_OR:           begin alu_op = ALU_OR;   reg_we = 1'b1; wra = rd; end
          FN_XOR:          begin alu_op = ALU_XOR;  reg_we = 1'b1; wra = rd; end
          FN_NOR:          begin alu_op = ALU_NOR;  reg_we = 1'b1; wra = rd; end
          FN_SLT:          begin alu_op = ALU_SLT;  reg_we = 1'b1; wra = rd; end
          FN_SLTU:         begin alu_op = ALU_SLTU; reg_we = 1'b1; wra = rd; end
          FN_SLL: begin
            alu_op = ALU_SLL; s_imme = 1'b1; s_a0 = 1'b1; s_b = 1'b1; reg_we = 1'b1; wra = rd;
          end
          FN_SRL: begin
            alu_op = ALU_SRL; s_imme = 1'b1; s_a0 = 1'b1; s_b = 1'b1; reg_we = 1'b1; wra = rd;
          end
          FN_SRA: begin
            alu_op = ALU_SRA; s_imme = 1'b1; s_a0 = 1'b1; s_b = 1'b1; reg_we = 1'b1; wra = rd;
          end
          FN_SLLV: begin alu_op = ALU_SLL; s_a0 = 1'b1; reg_we = 1'b1; wra = rd; end
          FN_SRLV: begin alu_op = ALU_SRL; s_a0 = 1'b1; reg_we = 1'b1; wra = rd; end
          FN_SRAV: begin alu_op = ALU_SRA; s_a0 = 1'b1; reg_we = 1'b1; wra = rd; end
          FN_JR:   begin br_op = BR_JR; end
          FN_JALR: begin
            br_op = BR_JALR; alu_op = ALU_LINK; s_a = 1'b1; reg_we = 1'b1; wra = rd;
          end
          default: begin end
        endcase
      end
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          br_op = BR_BLTZ; sign_ext = 1'b1;
        end else if (rt == 5'd1) begin
          br_op = BR_BGEZ; sign_ext = 1'b1;
        end
      end
      OP_J:   br_op = BR_J;
      OP_JAL: begin
        br_op = BR_JAL; alu_op = ALU_LINK; s_a = 1'b1; reg_we = 1'b1; wra = REG_RA;
      end
      OP_BEQ:  begin br_op = BR_BEQ;  sign_ext = 1'b1; end
      OP_BNE:  begin br_op = BR_BNE;  sign_ext = 1'b1; end
      OP_BLEZ: begin br_op = BR_BLEZ; sign_ext = 1'b1; end
      OP_BGTZ: begin br_op = BR_BGTZ; sign_ext = 1'b1; end
      OP_ADDI, OP_ADDIU: begin
        alu_op = ALU_ADD; sign_ext = 1'b1; s_b = 1'b1; reg_we = 1'b1; wra = rt;
      end
      OP_SLTI:  begin alu_op = ALU_SLT;  sign_ext = 1'b1; s_b = 1'b1; reg_we = 1'b1; wra = rt; end
      OP_SLTIU: begin alu_op = ALU_SLTU; sign_ext = 1'b1; s_b = 1'b1; reg_we = 1'b1; wra = rt; end
      OP_ANDI:  begin alu_op = ALU_AND; s_b = 1'b1; reg_we = 1'b1; wra = rt; end
      OP_ORI:   begin alu_op = ALU_OR;  s_b = 1'b1; reg_we = 1'b1; wra = rt; end
      OP_XORI:  begin alu_op = ALU_XOR; s_b = 1'b1; reg_we = 1'b1; wra = rt; end
      OP_LUI:   begin alu_op = ALU_LUI; s_b = 1'b1; reg_we = 1'b1; wra = rt; end
      OP_LW, OP_LB: begin
        alu_op = ALU_ADD; s_b = 1'b1; sign_ext = 1'b1; s_wrd = 1'b1; is_load = 1'b1;
        reg_we = 1'b1; wra = rt; s_byte = (op == OP_LB);
      end
      OP_SW, OP_SB: begin
        alu_op = ALU_ADD; s_b = 1'b1; sign_ext = 1'b1; dmem_we = 1'b1; s_byte = (op == OP_SB);
      end
      default: begin end
    endcase
  end

  // Shift amount travels through the immediate path as a small unsigned value.
  logic [IMMW-1:0] imm_sel;
  logic [XLEN-1:0] num_c;

  always_comb begin
    imm_sel = s_imme ? {11'b0, shamt} : imm16;
    num_c   = sign_ext ? {{(XLEN-IMMW){imm_sel[IMMW-1]}}, imm_sel}
                       : {{(XLEN-IMMW){1'b0}}, imm_sel};
  end

  assign imm16 = bus.inst[15:0];

  trk_t trk_e;
  trk_t trk_m;
  trk_t trk_w;
  trk_t trk_e_nxt;
  logic pause_c;

  // A stalled instruction enters E as a bubble so it is not seen as a producer twice.
  always_comb begin
    trk_e_nxt = '0;
    if (!pause_c) begin
      trk_e_nxt.wra  = wra;
      trk_e_nxt.we   = reg_we && (wra != REG_ZERO);
      trk_e_nxt.load = is_load;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trk_e <= '0;
      trk_m <= '0;
      trk_w <= '0;
    end else begin
      trk_w <= trk_m;
      trk_m <= trk_e;
      trk_e <= trk_e_nxt;
    end
  end

  function automatic logic fwd_hit(input trk_t t, input logic [RAW-1:0] r);
    fwd_hit = t.we && (t.wra == r);
  endfunction

  logic [XLEN-1:0] rd1_c;
  logic [XLEN-1:0] rd2_c;

  // Youngest producer wins; $0 is never forwarded.
  always_comb begin
    rd1_c = bus.rf_rd1;
    if (rs != REG_ZERO) begin
      if (fwd_hit(trk_e, rs))      rd1_c = bus.aluOutE;
      else if (fwd_hit(trk_m, rs)) rd1_c = bus.resM;
      else if (fwd_hit(trk_w, rs)) rd1_c = bus.rstW;
    end
  end

  always_comb begin
    rd2_c = bus.rf_rd2;
    if (rt != REG_ZERO) begin
      if (fwd_hit(trk_e, rt))      rd2_c = bus.aluOutE;
      else if (fwd_hit(trk_m, rt)) rd2_c = bus.resM;
      else if (fwd_hit(trk_w, rt)) rd2_c = bus.rstW;
    end
  end

  // Load data is not ready until M, so a consumer directly behind a load waits one cycle.
  always_comb begin
    pause_c = trk_e.load && trk_e.we &&
              (((rs != REG_ZERO) && (trk_e.wra == rs)) ||
               ((rt != REG_ZERO) && (trk_e.wra == rt)));
  end

  assign bus.rd1    = rd1_c;
  assign bus.rd2    = rd2_c;
  assign bus.num    = num_c;
  assign bus.wra    = wra;
  assign bus.aluOP  = alu_op;
  assign bus.brOP   = br_op;
  assign bus.sA0    = s_a0;
  assign bus.sA     = s_a;
  assign bus.sB     = s_b;
  assign bus.sWRD   = s_wrd;
  assign bus.sByte  = s_byte;
  assign bus.dMemWe = dmem_we;
  assign bus.regWe  = reg_we;
  assign bus.pause  = pause_c;
endmodule

// File: tb/tb_dec_ctrl_hazard.sv
// Bench for dec_ctrl_hazard: directed pipeline scenarios followed by random instruction
// streams, all checked against a mnemonic-level decode model and an issue-history model.
module tb_dec_ctrl_hazard;
  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  dec_ctrl_hazard_if bus ();

  dec_ctrl_hazard dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wra;
    logic [4:0]  alu;
    logic [3:0]  br;
    logic        sa0;
    logic        sa;
    logic        sb;
    logic        swrd;
    logic        sbyte;
    logic        dwe;
    logic        rwe;
    logic        load;
    logic [31:0] num;
  } exp_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       we;
    logic       load;
  } ent_t;

  // hist[0] is the most recently issued instruction (now in E), hist[2] is in W.
  ent_t hist [3];
  ent_t nxt_ent;
  logic last_pause;

  string alu_names [13] = '{"ADD", "SUB", "AND", "OR", "XOR", "NOR", "SLT", "SLTU",
                            "SLL", "SRL", "SRA", "LUI", "LINK"};
  string br_names  [11] = '{"-", "BEQ", "BNE", "BLEZ", "BGTZ", "BLTZ", "BGEZ",
                            "J", "JAL", "JR", "JALR"};
  logic [5:0] rfn [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h20,
                           6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] iop [21] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                           6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h23,
                           6'h23, 6'h28, 6'h2B};

  function automatic bit in_set(input string m, input string set);
    string key;
    key = {" ", m, " "};
    for (int k = 0; k + key.len() <= set.len(); k++)
      if (set.substr(k, k + key.len() - 1) == key) return 1'b1;
    return 1'b0;
  endfunction

  function automatic string mnem(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h00: return "SLL";   6'h02: return "SRL";   6'h03: return "SRA";
        6'h04: return "SLLV";  6'h06: return "SRLV";  6'h07: return "SRAV";
        6'h08: return "JR";    6'h09: return "JALR";
        6'h20: return "ADD";   6'h21: return "ADDU";  6'h22: return "SUB";
        6'h23: return "SUBU";  6'h24: return "AND";   6'h25: return "OR";
        6'h26: return "XOR";   6'h27: return "NOR";   6'h2A: return "SLT";
        6'h2B: return "SLTU";
        default: return "NOP";
      endcase
    end
    if (op == 6'h01) return (i[20:16] == 5'd0) ? "BLTZ" : (i[20:16] == 5'd1) ? "BGEZ" : "NOP";
    case (op)
      6'h02: return "J";     6'h03: return "JAL";   6'h04: return "BEQ";
      6'h05: return "BNE";   6'h06: return "BLEZ";  6'h07: return "BGTZ";
      6'h08: return "ADDI";  6'h09: return "ADDIU"; 6'h0A: return "SLTI";
      6'h0B: return "SLTIU"; 6'h0C: return "ANDI";  6'h0D: return "ORI";
      6'h0E: return "XORI";  6'h0F: return "LUI";   6'h20: return "LB";
      6'h23: return "LW";    6'h28: return "SB";    6'h2B: return "SW";
      default: return "NOP";
    endcase
  endfunction

  function automatic string alu_base(input string m);
    if (in_set(m, " JAL JALR ")) return "LINK";
    if (in_set(m, " ADDU ADDI ADDIU LW LB SW SB ")) return "ADD";
    if (m == "SUBU") return "SUB";
    if (m == "SLTI") return "SLT";
    if (m == "SLTIU") return "SLTU";
    if (m == "ANDI") return "AND";
    if (m == "ORI") return "OR";
    if (m == "XORI") return "XOR";
    if (m == "SLLV") return "SLL";
    if (m == "SRLV") return "SRL";
    if (m == "SRAV") return "SRA";
    return m;
  endfunction

  function automatic exp_t model_dec(input logic [31:0] i);
    exp_t  e;
    string m;
    string a;
    logic [15:0] imm;
    string r_writers;
    string i_writers;
    e = '0;
    m = mnem(i);
    a = alu_base(m);
    r_writers = " ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JALR ";
    i_writers = " ADDI ADDIU SLTI SLTIU ANDI ORI XORI LUI LW LB ";
    for (int k = 0; k < 13; k++) if (alu_names[k] == a) e.alu = 5'(k);
    for (int k = 1; k < 11; k++) if (br_names[k] == m) e.br = 4'(k);
    e.sa0   = in_set(m, " SLL SRL SRA SLLV SRLV SRAV ");
    e.sa    = in_set(m, " JAL JALR ");
    e.sb    = in_set(m, " SLL SRL SRA ADDI ADDIU SLTI SLTIU ANDI ORI XORI LUI LW LB SW SB ");
    e.swrd  = in_set(m, " LW LB ");
    e.load  = e.swrd;
    e.sbyte = in_set(m, " LB SB ");
    e.dwe   = in_set(m, " SW SB ");
    if (in_set(m, r_writers))      begin e.wra = i[15:11]; e.rwe = 1'b1; end
    else if (in_set(m, i_writers)) begin e.wra = i[20:16]; e.rwe = 1'b1; end
    else if (m == "JAL")           begin e.wra = 5'd31;    e.rwe = 1'b1; end
    imm = in_set(m, " SLL SRL SRA ") ? {11'b0, i[10:6]} : i[15:0];
    e.num = in_set(m, " ADDI ADDIU SLTI SLTIU LW LB SW SB BEQ BNE BLEZ BGTZ BLTZ BGEZ ")
            ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    return e;
  endfunction

  // Operand a source register should see: newest in-flight writer, else the register file.
  function automatic logic [31:0] pick(input logic [4:0] r, input logic [31:0] rf);
    logic [31:0] stage_data [3];
    stage_data[0] = bus.aluOutE;
    stage_data[1] = bus.resM;
    stage_data[2] = bus.rstW;
    if (r == 5'd0) return rf;
    for (int age = 0; age < 3; age++)
      if (hist[age].we && hist[age].dst == r) return stage_data[age];
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 3; k++) hist[k] = '0;
  endtask

  task automatic drive(input logic [31:0] i);
    bus.inst    = i;
    bus.rf_rd1  = $urandom;
    bus.rf_rd2  = $urandom;
    bus.aluOutE = $urandom;
    bus.resM    = $urandom;
    bus.rstW    = $urandom;
  endtask

  task automatic compare(input string tag);
    exp_t e;
    logic [4:0] rs;
    logic [4:0] rt;
    logic p;
    e  = model_dec(bus.inst);
    rs = bus.inst[25:21];
    rt = bus.inst[20:16];
    p  = hist[0].load && hist[0].we &&
         ((rs != 5'd0 && hist[0].dst == rs) || (rt != 5'd0 && hist[0].dst == rt));
    chk({tag, ".rd1"},    bus.rd1, pick(rs, bus.rf_rd1));
    chk({tag, ".rd2"},    bus.rd2, pick(rt, bus.rf_rd2));
    chk({tag, ".num"},    bus.num, e.num);
    chk({tag, ".wra"},    32'(bus.wra), 32'(e.wra));
    chk({tag, ".aluOP"},  32'(bus.aluOP), 32'(e.alu));
    chk({tag, ".brOP"},   32'(bus.brOP), 32'(e.br));
    chk({tag, ".sA0"},    32'(bus.sA0), 32'(e.sa0));
    chk({tag, ".sA"},     32'(bus.sA), 32'(e.sa));
    chk({tag, ".sB"},     32'(bus.sB), 32'(e.sb));
    chk({tag, ".sWRD"},   32'(bus.sWRD), 32'(e.swrd));
    chk({tag, ".sByte"},  32'(bus.sByte), 32'(e.sbyte));
    chk({tag, ".dMemWe"}, 32'(bus.dMemWe), 32'(e.dwe));
    chk({tag, ".regWe"},  32'(bus.regWe), 32'(e.rwe));
    chk({tag, ".pause"},  32'(bus.pause), 32'(p));
    last_pause = p;
    nxt_ent = p ? '0 : '{dst: e.wra, we: e.rwe && (e.wra != 5'd0), load: e.load};
  endtask

  task automatic pre(input logic [31:0] i, input string tag);
    @(negedge clk);
    drive(i);
    #1;
    compare(tag);
  endtask

  task automatic post();
    @(posedge clk);
    if (!rstn) clear_hist();
    else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nxt_ent;
    end
  endtask

  // Reset asserted between edges: tracker must clear at once, not on the next clock.
  task automatic mid_reset(input logic [31:0] i, input string tag);
    @(negedge clk);
    rstn = 1'b0;
    drive(i);
    #1;
    clear_hist();
    compare(tag);
    chk({tag, ".pause0"}, 32'(bus.pause), 32'd0);
    chk({tag, ".rd1rf"}, bus.rd1, bus.rf_rd1);
    post();
    #2 rstn = 1'b1;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0:       return $urandom;
      1, 2, 3: return enc_r(rfn[int'($urandom_range(0, 17))], rd, rs, rt, 5'($urandom));
      default: return enc_i(iop[int'($urandom_range(0, 20))], rs, rt, 16'($urandom));
    endcase
  endfunction

  logic [31:0] cur;

  initial begin
    checks     = 0;
    failures   = 0;
    last_pause = 1'b0;
    nxt_ent    = '0;
    rstn       = 1'b0;
    drive(32'h0);
    clear_hist();

    // Reset state: nothing tracked, so no forwarding and no stall.
    pre(enc_r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0), "reset");
    chk("reset.pause0", 32'(bus.pause), 32'd0);
    chk("reset.rd1rf", bus.rd1, bus.rf_rd1);
    post();
    #2 rstn = 1'b1;

    // ALU result forwarded straight from E.
    pre(enc_r(6'h20, 5'd3, 5'd1, 5'd2, 5'd0), "add3");
    post();
    pre(enc_r(6'h22, 5'd4, 5'd3, 5'd1, 5'd0), "sub4");
    chk("sub4.fwdE", bus.rd1, bus.aluOutE);
    chk("sub4.nostall", 32'(bus.pause), 32'd0);
    chk("sub4.aluSUB", 32'(bus.aluOP), 32'd1);
    post();

    // Load-use: one stall cycle, then both operands from M.
    pre(enc_i(6'h23, 5'd0, 5'd5, 16'h0000), "lw5");
    post();
    pre(enc_r(6'h20, 5'd6, 5'd5, 5'd5, 5'd0), "use5a");
    chk("use5a.stall", 32'(bus.pause), 32'd1);
    post();
    pre(enc_r(6'h20, 5'd6, 5'd5, 5'd5, 5'd0), "use5b");
    chk("use5b.nostall", 32'(bus.pause), 32'd0);
    chk("use5b.rd1M", bus.rd1, bus.resM);
    chk("use5b.rd2M", bus.rd2, bus.resM);
    post();

    // Immediate extension and shift amount.
    pre(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFF), "addi");
    chk("addi.num", bus.num, 32'hFFFF_FFFF);
    chk("addi.sB", 32'(bus.sB), 32'd1);
    post();
    pre(enc_i(6'h0D, 5'd0, 5'd2, 16'hFFFF), "ori");
    chk("ori.num", bus.num, 32'h0000_FFFF);
    post();
    pre(enc_r(6'h00, 5'd1, 5'd0, 5'd2, 5'd5), "sll");
    chk("sll.num", bus.num, 32'd5);
    chk("sll.sA0", 32'(bus.sA0), 32'd1);
    chk("sll.aluOP", 32'(bus.aluOP), 32'd8);
    post();
    pre({6'h03, 26'h0000123}, "jal");
    chk("jal.wra", 32'(bus.wra), 32'd31);
    chk("jal.regWe", 32'(bus.regWe), 32'd1);
    chk("jal.brOP", 32'(bus.brOP), 32'd8);
    post();

    // Writes to $0 are never forwarded.
    pre(enc_r(6'h20, 5'd0, 5'd1, 5'd2, 5'd0), "wr0");
    post();
    pre(enc_r(6'h20, 5'd3, 5'd0, 5'd0, 5'd0), "rd0");
    chk("rd0.rd1rf", bus.rd1, bus.rf_rd1);
    chk("rd0.rd2rf", bus.rd2, bus.rf_rd2);
    post();

    // Reset mid-stream right behind a load.
    pre(enc_i(6'h23, 5'd0, 5'd5, 16'h0004), "lw5r");
    post();
    mid_reset(enc_r(6'h20, 5'd6, 5'd5, 5'd5, 5'd0), "rstmid");
    pre(enc_r(6'h20, 5'd6, 5'd5, 5'd5, 5'd0), "postrst");
    chk("postrst.pause0", 32'(bus.pause), 32'd0);
    chk("postrst.rd1rf", bus.rd1, bus.rf_rd1);
    post();

    // Random streams over a few registers; a stalled instruction is held as IF/ID would.
    cur = 32'h0;
    for (int n = 0; n < 600; n++) begin
      if (!last_pause) cur = rand_inst();
      if (n == 300) mid_reset(cur, "rndrst");
      else begin
        pre(cur, "rnd");
        post();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
